// File: rtl/amber128_reset_pkg.sv
// Shared types and constants for the amber128 reset sequencer.
//   state_e   : sequencer FSM states
//   CAUSE_*   : bit positions within the sticky reset-cause vector
//   CAUSE_W   : width of the reset-cause vector
package amber128_reset_pkg;

  typedef enum logic [1:0] {
    ASSERT,
    RELEASE,
    RUN
  } state_e;

  localparam int unsigned CAUSE_POR = 0;
  localparam int unsigned CAUSE_SW  = 1;
  localparam int unsigned CAUSE_WDT = 2;
  localparam int unsigned CAUSE_PLL = 3;
  localparam int unsigned CAUSE_W   = 4;

endpackage

// File: rtl/amber128_reset_seq.sv
// Central reset generator/sequencer. Merges power-on, software, watchdog and PLL-lock-loss
// reset sources, holds every domain in reset for HOLD_CYCLES quiet cycles, then releases the
// domains one at a time in index order, STEP_CYCLES apart. Records the cause of the last reset.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high power-on reset
//   sw_req_i       software reset request (level)
//   wdt_req_i      watchdog reset request (level)
//   pll_locked_i   PLL lock, already synchronous to clk_i
//   cause_clr_i    single-cycle pulse clearing cause_o
//   dom_rst_no     per-domain active-low reset, feeds downstream synchronizers
//   all_released_o high while every domain is out of reset
//   cause_o        sticky cause: [0] POR, [1] SW, [2] WDT, [3] PLL
module amber128_reset_seq
  import amber128_reset_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STEP_CYCLES = 8,
  parameter int unsigned CNT_W       =
    $clog2((HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sw_req_i,
  input  logic                   wdt_req_i,
  input  logic                   pll_locked_i,
  input  logic                   cause_clr_i,
  output logic [NUM_DOMAINS-1:0] dom_rst_no,
  output logic                   all_released_o,
  output logic [CAUSE_W-1:0]     cause_o
);

  localparam int unsigned CntMax = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int unsigned IdxW   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  if (NUM_DOMAINS < 1) begin : g_chk_dom
    $fatal(1, "amber128_reset_seq: NUM_DOMAINS must be >= 1");
  end
  if (HOLD_CYCLES < 2) begin : g_chk_hold
    $fatal(1, "amber128_reset_seq: HOLD_CYCLES must be >= 2");
  end
  if (STEP_CYCLES < 1) begin : g_chk_step
    $fatal(1, "amber128_reset_seq: STEP_CYCLES must be >= 1");
  end

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   all_q, all_d;
  logic [CAUSE_W-1:0]     cause_q, cause_d;
  logic                   req_event;

  assign req_event = sw_req_i | wdt_req_i | ~pll_locked_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    all_d   = all_q;
    cause_d = cause_q;

    if (req_event) begin
      // Any request restarts the whole sequence and overwrites the cause; it beats a clear.
      state_d              = ASSERT;
      cnt_d                = '0;
      idx_d                = '0;
      dom_d                = '0;
      all_d                = 1'b0;
      cause_d              = '0;
      cause_d[CAUSE_SW]    = sw_req_i;
      cause_d[CAUSE_WDT]   = wdt_req_i;
      cause_d[CAUSE_PLL]   = ~pll_locked_i;
    end else begin
      if (cause_clr_i) begin
        cause_d = '0;
      end
      unique case (state_q)
        ASSERT: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            state_d = RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = NUM_DOMAINS'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
            cnt_d = '0;
            if (idx_q == IdxW'(NUM_DOMAINS - 1)) begin
              state_d = RUN;
              all_d   = 1'b1;
            end else begin
              idx_d = idx_q + IdxW'(1);
              // Released bits always form a thermometer code from bit 0, so extend it by one.
              dom_d = (dom_q << 1) | NUM_DOMAINS'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
        end
        default: begin
          state_d = ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
          dom_d   = '0;
          all_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      all_q   <= 1'b0;
      cause_q <= CAUSE_W'(1) << CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      all_q   <= all_d;
      cause_q <= cause_d;
    end
  end

  assign dom_rst_no     = dom_q;
  assign all_released_o = all_q;
  assign cause_o        = cause_q;

  cnt_bound_a: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q < CNT_W'(CntMax));

endmodule

// File: tb/tb_amber128_reset_seq.sv
// Self-checking bench for amber128_reset_seq with HOLD_CYCLES=4, STEP_CYCLES=2, NUM_DOMAINS=3.
module tb_amber128_reset_seq;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       sw_req_i = 1'b0;
  logic       wdt_req_i = 1'b0;
  logic       pll_locked_i = 1'b1;
  logic       cause_clr_i = 1'b0;
  logic [2:0] dom_rst_no;
  logic       all_released_o;
  logic [3:0] cause_o;

  amber128_reset_seq #(
    .NUM_DOMAINS(3),
    .HOLD_CYCLES(4),
    .STEP_CYCLES(2)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .sw_req_i      (sw_req_i),
    .wdt_req_i     (wdt_req_i),
    .pll_locked_i  (pll_locked_i),
    .cause_clr_i   (cause_clr_i),
    .dom_rst_no    (dom_rst_no),
    .all_released_o(all_released_o),
    .cause_o       (cause_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs held for 'reps' cycles; expected outputs apply after every one of those edges.
  typedef struct {
    logic       rst, sw, wdt, lck, clr;
    int         reps;
    logic [2:0] dom;
    logic       all;
    logic [3:0] cause;
    string      name;
  } vec_t;

  typedef struct {
    logic [2:0] dom;
    logic       all;
    logic [3:0] cause;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic rst, logic sw, logic wdt, logic lck, logic clr, int reps,
                              logic [2:0] dom, logic all, logic [3:0] cause, string name);
    vec_t v;
    v.rst = rst; v.sw = sw; v.wdt = wdt; v.lck = lck; v.clr = clr; v.reps = reps;
    v.dom = dom; v.all = all; v.cause = cause; v.name = name;
    return v;
  endfunction

  // Quiet inputs after a reset event: release after edge 4, then 6, 8, RUN after edge 10.
  task automatic add_release(input logic [3:0] cause, input string tag);
    vecs.push_back(mk(0, 0, 0, 1, 0, 3, 3'b000, 0, cause, {tag, "_hold"}));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 3'b001, 0, cause, {tag, "_dom0"}));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 3'b011, 0, cause, {tag, "_dom1"}));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 3'b111, 0, cause, {tag, "_dom2"}));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3'b111, 1, cause, {tag, "_run"}));
  endtask

  task automatic check_edge();
    exp_t       e;
    logic [2:0] t;
    e = sb.pop_front();
    n_cmp++;
    if (dom_rst_no !== e.dom || all_released_o !== e.all || cause_o !== e.cause) begin
      n_err++;
      $display("FAIL %s: got dom=%b all=%b cause=%b, expected dom=%b all=%b cause=%b",
               e.name, dom_rst_no, all_released_o, cause_o, e.dom, e.all, e.cause);
    end
    // Released bits must always be a contiguous run starting at bit 0.
    t = dom_rst_no + 3'd1;
    n_cmp++;
    if ((t & dom_rst_no) !== 3'b000) begin
      n_err++;
      $display("FAIL %s_shape: got dom=%b, expected 0..01..1 form", e.name, dom_rst_no);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    for (int r = 0; r < v.reps; r++) begin
      @(negedge clk_i);
      rst_i        = v.rst;
      sw_req_i     = v.sw;
      wdt_req_i    = v.wdt;
      pll_locked_i = v.lck;
      cause_clr_i  = v.clr;
      e.dom = v.dom; e.all = v.all; e.cause = v.cause; e.name = v.name;
      sb.push_back(e);
      @(posedge clk_i);
      #1;
      check_edge();
    end
  endtask

  initial begin
    // POR
    vecs.push_back(mk(1, 0, 0, 1, 0, 3, 3'b000, 0, 4'b0001, "por_rst"));
    add_release(4'b0001, "por");
    vecs.push_back(mk(0, 0, 0, 1, 0, 3, 3'b111, 1, 4'b0001, "por_run_hold"));
    // Software request in RUN
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 3'b000, 0, 4'b0010, "sw_hit"));
    add_release(4'b0010, "sw");
    // Watchdog during RELEASE while dom=011
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 3'b000, 0, 4'b0010, "pre_wdt_sw"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 3, 3'b000, 0, 4'b0010, "pre_wdt_hold"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 3'b001, 0, 4'b0010, "pre_wdt_dom0"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3'b011, 0, 4'b0010, "pre_wdt_dom1"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 3'b000, 0, 4'b0100, "wdt_hit"));
    add_release(4'b0100, "wdt");
    // Simultaneous sources plus clear: event wins
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 3'b000, 0, 4'b0110, "simul_hit"));
    add_release(4'b0110, "simul");
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 3'b111, 1, 4'b0000, "clr_in_run"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 3'b111, 1, 4'b0000, "clr_after"));
    // Held software request
    vecs.push_back(mk(0, 1, 0, 1, 0, 20, 3'b000, 0, 4'b0010, "sw_held"));
    add_release(4'b0010, "sw_held");
    // PLL unlocked after reset
    vecs.push_back(mk(1, 0, 0, 1, 0, 2, 3'b000, 0, 4'b0001, "pll_rst"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10, 3'b000, 0, 4'b1000, "pll_unlocked"));
    add_release(4'b1000, "pll");
    // rst_i mid-release drops everything on the same edge
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 3'b000, 0, 4'b0010, "mid_sw"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 3, 3'b000, 0, 4'b0010, "mid_hold"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3'b001, 0, 4'b0010, "mid_dom0"));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 3'b000, 0, 4'b0001, "mid_rst"));
    // Clear while still holding (no event) clears cause; sequence continues unaffected
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 3'b000, 0, 4'b0000, "clr_hold"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 3'b000, 0, 4'b0000, "clr_hold2"));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3'b001, 0, 4'b0000, "clr_dom0"));

    foreach (vecs[i]) apply(vecs[i]);

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
